// File: rtl/video_wr_burst_ctrl.sv
// video_wr_burst_ctrl: buffers a de-qualified pixel stream in a FIFO and issues fixed-length DDR write bursts
// Ports: pixclk_in/rst (async, active-high); vs_in/de_in/wr_data are the scaler pixel stream;
//        wr_req/wr_addr/wr_len/wr_ack form the burst request handshake; wr_rd_en/wr_dout pop burst words;
//        frame_idx is the frame being written, frame_done pulses at frame close, fifo_ovf is sticky on drop.
// Macro VIDEO_WR_PINGPONG_EN: when defined, frame_idx toggles per frame so bases alternate FRAME_BASE0/FRAME_BASE1.
module video_wr_burst_ctrl #(
  parameter int DATA_W = 32,
  parameter int FIFO_DEPTH = 512,
  parameter int BURST_LEN = 64,
  parameter int ADDR_W = 28,
  parameter logic [ADDR_W-1:0] FRAME_BASE0 = 28'h0000000,
  parameter logic [ADDR_W-1:0] FRAME_BASE1 = 28'h0080000
) (
  input  logic              pixclk_in,
  input  logic              rst,
  input  logic              vs_in,
  input  logic              de_in,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [8:0]        wr_len,
  input  logic              wr_ack,
  input  logic              wr_rd_en,
  output logic [DATA_W-1:0] wr_dout,
  output logic              frame_idx,
  output logic              frame_done,
  output logic              fifo_ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] BL_C = (AW+1)'(BURST_LEN);
  localparam logic [AW:0] FULL_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE_C = (AW+1)'(1);
  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp, fifo_cnt;
  logic [ADDR_W-1:0] wr_ofs;
  logic [8:0] pop_cnt;
  logic vs_q, flush_pend, full, empty, push, pop, close;
  // Pointers carry one extra bit so their difference is the occupancy, 0..FIFO_DEPTH.
  assign fifo_cnt = wp - rp;
  assign full = fifo_cnt == FULL_C;
  assign empty = fifo_cnt == '0;
  assign push = de_in && !vs_in && !full;
  assign pop = state == DATA && wr_rd_en && !empty;
  assign close = state == IDLE && flush_pend && empty;
  always_ff @(posedge pixclk_in)
    if (push) mem[wp[AW-1:0]] <= wr_data;
  always_ff @(posedge pixclk_in or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wr_req <= 1'b0;
      wr_addr <= '0;
      wr_len <= '0;
      wr_dout <= '0;
      frame_idx <= 1'b0;
      frame_done <= 1'b0;
      fifo_ovf <= 1'b0;
      wp <= '0;
      rp <= '0;
      wr_ofs <= '0;
      flush_pend <= 1'b0;
      vs_q <= 1'b0;
      pop_cnt <= '0;
    end else begin
      vs_q <= vs_in;
      frame_done <= close;
      // A new vs rise wins over a same-cycle close so the next frame still gets flushed.
      flush_pend <= (vs_in && !vs_q) || (flush_pend && !close);
      if (de_in && !vs_in && full) fifo_ovf <= 1'b1;
      if (push) wp <= wp + ONE_C;
      if (pop) begin
        rp <= rp + ONE_C;
        wr_dout <= mem[rp[AW-1:0]];
      end
      case (state)
        IDLE:
          if (fifo_cnt >= BL_C || (flush_pend && !empty)) begin
            state <= REQ;
            wr_req <= 1'b1;
            wr_len <= fifo_cnt >= BL_C ? 9'(BURST_LEN) : 9'(fifo_cnt);
            wr_addr <= (frame_idx ? FRAME_BASE1 : FRAME_BASE0) + wr_ofs;
          end else if (close) begin
            wr_ofs <= '0;
`ifdef VIDEO_WR_PINGPONG_EN
            frame_idx <= !frame_idx;
`else
            frame_idx <= 1'b0;
`endif
          end
        REQ:
          if (wr_ack) begin
            state <= DATA;
            wr_req <= 1'b0;
          end
        DATA:
          if (pop) begin
            pop_cnt <= pop_cnt == wr_len - 9'd1 ? '0 : pop_cnt + 9'd1;
            if (pop_cnt == wr_len - 9'd1) begin
              state <= IDLE;
              wr_ofs <= wr_ofs + ADDR_W'(wr_len);
            end
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_video_wr_burst_ctrl.sv
// tb_video_wr_burst_ctrl: directed bench with a queue-based reference model for video_wr_burst_ctrl
module tb_video_wr_burst_ctrl;
  localparam int BL = 64;
  localparam int DEPTH = 512;
`ifdef VIDEO_WR_PINGPONG_EN
  localparam logic [27:0] NEXT_BASE = 28'h0080000;
  localparam logic PP = 1'b1;
`else
  localparam logic [27:0] NEXT_BASE = 28'h0000000;
  localparam logic PP = 1'b0;
`endif
  logic pixclk_in = 1'b0, rst = 1'b1, vs_in = 1'b0, de_in = 1'b0, wr_ack = 1'b0, wr_rd_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic wr_req, frame_idx, frame_done, fifo_ovf;
  logic [27:0] wr_addr;
  logic [8:0] wr_len;
  logic [31:0] wr_dout;
  int n_cmp = 0, n_err = 0, n_done = 0;

  video_wr_burst_ctrl dut (
    .pixclk_in(pixclk_in), .rst(rst), .vs_in(vs_in), .de_in(de_in), .wr_data(wr_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_ack(wr_ack), .wr_rd_en(wr_rd_en),
    .wr_dout(wr_dout), .frame_idx(frame_idx), .frame_done(frame_done), .fifo_ovf(fifo_ovf)
  );

  always #5 pixclk_in = ~pixclk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, bursts as (address, length, remaining) transactions.
  logic [31:0] q[$];
  int m_ph, m_len, m_left, m_sz;
  logic [27:0] m_ofs, m_addr;
  logic [31:0] m_dout;
  logic m_idx, m_done, m_ovf, m_vsq, m_flush, m_push, m_pop, m_rise, m_close;
  logic i_rst = 1'b1, i_de = 1'b0, i_vs = 1'b0, i_ack = 1'b0, i_rd = 1'b0;
  logic [31:0] i_data = '0;

  always @(negedge pixclk_in) begin
    if (rst || i_rst) begin
      q.delete();
      m_ph = 0; m_len = 0; m_left = 0; m_ofs = '0; m_addr = '0; m_dout = '0;
      m_idx = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_vsq = 1'b0; m_flush = 1'b0;
      chk("rst_req", wr_req, 0);
      chk("rst_addr", wr_addr, 0);
      chk("rst_len", wr_len, 0);
      chk("rst_dout", wr_dout, 0);
      chk("rst_idx", frame_idx, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_ovf", fifo_ovf, 0);
    end else begin
      m_sz = q.size();
      m_push = i_de && !i_vs && m_sz < DEPTH;
      m_pop = m_ph == 2 && i_rd && m_sz > 0;
      m_rise = i_vs && !m_vsq;
      m_close = m_ph == 0 && m_flush && m_sz == 0;
      m_done = 1'b0;
      if (m_ph == 0) begin
        if (m_sz >= BL || (m_flush && m_sz > 0)) begin
          m_ph = 1;
          m_len = m_sz >= BL ? BL : m_sz;
          m_addr = (m_idx ? 28'h0080000 : 28'h0) + m_ofs;
        end else if (m_flush) begin
          m_done = 1'b1;
          m_ofs = '0;
          if (PP) m_idx = !m_idx;
        end
      end else if (m_ph == 1) begin
        if (i_ack) begin m_ph = 2; m_left = m_len; end
      end else if (m_pop) begin
        m_left--;
        if (m_left == 0) begin m_ph = 0; m_ofs = m_ofs + 28'(m_len); end
      end
      m_flush = m_rise || (m_flush && !m_close);
      if (m_pop) m_dout = q.pop_front();
      if (m_push) q.push_back(i_data);
      if (i_de && !i_vs && m_sz == DEPTH) m_ovf = 1'b1;
      m_vsq = i_vs;
      chk("m_req", wr_req, m_ph == 1);
      if (m_ph != 0) begin
        chk("m_addr", wr_addr, m_addr);
        chk("m_len", wr_len, m_len);
      end
      chk("m_done", frame_done, m_done);
      chk("m_idx", frame_idx, m_idx);
      chk("m_ovf", fifo_ovf, m_ovf);
      chk("m_dout", wr_dout, m_dout);
      if (frame_done) n_done++;
    end
    i_rst = rst; i_de = de_in; i_vs = vs_in; i_ack = wr_ack; i_rd = wr_rd_en; i_data = wr_data;
  end

  task automatic tick();
    @(posedge pixclk_in);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; vs_in = 1'b0; de_in = 1'b0; wr_ack = 1'b0; wr_rd_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic push_n(input int n, input logic [31:0] v0);
    for (int i = 0; i < n; i++) begin
      de_in = 1'b1; wr_data = v0 + 32'(i);
      tick();
    end
    de_in = 1'b0;
  endtask

  task automatic vs_pulse();
    vs_in = 1'b1;
    tick(); tick(); tick();
    vs_in = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int t = 0;
    while (!wr_req && t < 2000) begin tick(); t++; end
    chk({name, "_req_seen"}, wr_req, 1);
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (!frame_done && t < 500) begin tick(); t++; end
    chk({name, "_done_seen"}, frame_done, 1);
  endtask

  task automatic burst(input string name, input logic [27:0] addr, input int len,
                       input logic [31:0] v0, input int ack_dly, input int vs_at);
    wait_req(name);
    chk({name, "_addr"}, wr_addr, addr);
    chk({name, "_len"}, wr_len, len);
    for (int i = 0; i < ack_dly; i++) begin
      tick();
      chk({name, "_hold_req"}, wr_req, 1);
      chk({name, "_hold_addr"}, wr_addr, addr);
      chk({name, "_hold_len"}, wr_len, len);
    end
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0; wr_rd_en = 1'b1;
    for (int k = 0; k < len; k++) begin
      if (k == vs_at) vs_in = 1'b1;
      if (k == vs_at + 3) vs_in = 1'b0;
      tick();
      chk({name, "_dout"}, wr_dout, v0 + 32'(k));
    end
    wr_rd_en = 1'b0;
  endtask

  initial begin
    int d0;
    tick();
    chk("t0_req", wr_req, 0);
    chk("t0_addr", wr_addr, 0);
    chk("t0_len", wr_len, 0);
    chk("t0_ovf", fifo_ovf, 0);
    do_reset();
    // single full burst
    push_n(64, 32'h0000_0100);
    burst("t1", 28'h0, 64, 32'h0000_0100, 0, -1);
    repeat (5) tick();
    chk("t1_idle", wr_req, 0);
    // partial flush at frame boundary, then next frame base
    do_reset();
    push_n(100, 32'h0000_1000);
    burst("t2a", 28'h0, 64, 32'h0000_1000, 0, -1);
    d0 = n_done;
    vs_pulse();
    burst("t2b", 28'h40, 36, 32'h0000_1040, 0, -1);
    wait_done("t2");
    repeat (10) tick();
    chk("t2_done_cnt", n_done - d0, 1);
    chk("t2_idx", frame_idx, PP);
    push_n(64, 32'h0000_1100);
    burst("t2c", NEXT_BASE, 64, 32'h0000_1100, 0, -1);
    // overflow with request held off
    do_reset();
    push_n(600, 32'h0000_2000);
    chk("t3_ovf", fifo_ovf, 1);
    for (int b = 0; b < 8; b++)
      burst("t3", 28'(64 * b), 64, 32'h0000_2000 + 32'(64 * b), 0, -1);
    repeat (5) tick();
    chk("t3_ovf_sticky", fifo_ovf, 1);
    chk("t3_idle", wr_req, 0);
    // vs rise mid-burst does not truncate it
    do_reset();
    push_n(80, 32'h0000_3000);
    d0 = n_done;
    burst("t4a", 28'h0, 64, 32'h0000_3000, 0, 10);
    burst("t4b", 28'h40, 16, 32'h0000_3040, 0, -1);
    wait_done("t4");
    repeat (5) tick();
    chk("t4_done_cnt", n_done - d0, 1);
    // asynchronous reset mid-burst
    do_reset();
    push_n(64, 32'h0000_4000);
    wait_req("t5a");
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0; wr_rd_en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      chk("t5a_dout", wr_dout, 32'h0000_4000 + 32'(k));
    end
    #1 rst = 1'b1;
    #1;
    chk("t5_async_req", wr_req, 0);
    chk("t5_async_addr", wr_addr, 0);
    chk("t5_async_len", wr_len, 0);
    chk("t5_async_dout", wr_dout, 0);
    chk("t5_async_done", frame_done, 0);
    wr_rd_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    push_n(64, 32'h0000_5000);
    burst("t5b", 28'h0, 64, 32'h0000_5000, 0, -1);
    // delayed ack while pixels keep arriving
    do_reset();
    fork
      push_n(200, 32'h0000_6000);
      begin
        burst("t6a", 28'h0, 64, 32'h0000_6000, 20, -1);
        burst("t6b", 28'h40, 64, 32'h0000_6040, 0, -1);
        burst("t6c", 28'h80, 64, 32'h0000_6080, 0, -1);
      end
    join
    vs_pulse();
    burst("t6d", 28'hC0, 8, 32'h0000_60C0, 0, -1);
    wait_done("t6");
    chk("t6_ovf", fifo_ovf, 0);
    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_err);
    $fatal(1, "watchdog");
  end
endmodule
